raycast_column_scheduler: RTL
=============================

Name: raycast_column_scheduler

Overview:
- Sequences one frame of ray casting across screen columns.
- Per column: computes the ray angle, launches the horizontal and vertical wall-intersection finders in parallel, and waits for both to end.
- Selects the nearer hit and hands one result record per column to the renderer over a valid/ready handshake.
- Sits between player-state registers and the column renderer; it owns the finders' begin_calc inputs.

Parameters:
NUM_COLS, 320, columns per frame; the column index is $clog2(NUM_COLS) bits wide.
FOV_HALF, 30720, half field of view in Q10.10 degrees (30.0 deg).
ANGLE_STEP, 192, per-column angle decrement in Q10.10 degrees (60 deg / 320).
MAX_WAIT, 1024, cycle limit while waiting for the finders (used only with the optional feature).

Ports:
clock  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-high reset
frame_start  in  1  one-cycle pulse that starts a frame; ignored while busy
playerX, playerY  in  13 signed  player position, latched on frame_start
player_alpha_X  in  10 signed  player heading, integer degrees 0..359
player_alpha_Y  in  10  player heading, fractional bits
alpha_X  out  10 signed  current ray angle, integer part, to both finders
alpha_Y  out  10  current ray angle, fractional part, to both finders
ray_playerX, ray_playerY  out  13 signed  latched player position, to both finders
begin_calc  out  1  one-cycle launch pulse to both finders
h_end, v_end  in  1  end_calc from the horizontal / vertical finder
h_found, v_found  in  1  wall_found from each finder, sampled with its end
h_wallX, h_wallY, v_wallX, v_wallY  in  13 signed  hit coordinates, sampled with end
col_valid  out  1  result record valid
col_ready  in  1  renderer accepts the record
col_index  out  $clog2(NUM_COLS)  column number
hit_x, hit_y  out  13 signed  selected hit coordinates
hit_vert  out  1  1 = vertical-finder hit chosen
hit_found  out  1  0 = no wall on either finder
dist_sq  out  27  squared Euclidean distance from the player to the hit
busy  out  1  high from frame acceptance until frame_done
frame_done  out  1  one-cycle pulse after the last column is accepted

Behaviour:
- Reset (asynchronous): state IDLE. All outputs 0, including begin_calc, col_valid, busy and frame_done.
- Angle register A is 20 bits: {integer, fraction} Q10.10.
  - On frame_start: A = player angle + FOV_HALF.
  - Each new column: A = A - ANGLE_STEP.
  - Wrap after every update: if A >= 360<<10, subtract 360<<10; if A < 0, add 360<<10.
- IDLE: on frame_start, latch the player inputs, set the angle, clear the column counter, set busy, go to LAUNCH.
- LAUNCH: begin_calc = 1 for exactly one cycle. Clear the h_done/v_done flags. Go to WAIT.
- WAIT:
  - On h_end (or v_end), capture that finder's found flag and coordinates and set h_done (v_done). The two ends may arrive in any order or the same cycle.
  - Once both done flags are set, go to SELECT.
  - Ends seen outside WAIT are ignored.
- SELECT, 1 cycle:
  - For each found hit: d = dx*dx + dy*dy, where dx/dy are 14-bit signed differences from the latched player position and d is 27 bits unsigned.
  - Choose the found hit with the smaller d. A tie chooses horizontal (hit_vert = 0).
  - If neither hit is found: hit_found = 0, coordinates 0, dist_sq = all ones.
  - Register the record, go to OUTPUT.
- OUTPUT:
  - col_valid = 1; the record is held stable until col_ready.
  - A transfer occurs when col_valid && col_ready.
  - On transfer:
    - If col_index == NUM_COLS-1: go to DONE.
    - Otherwise: increment col_index, step the angle, go to LAUNCH.
  - col_valid drops the cycle after the transfer.
- DONE: frame_done = 1 for one cycle, busy cleared, return to IDLE.
- Latency with col_ready held high: LAUNCH 1 + WAIT (the slower finder's latency + 1) + SELECT 1 + OUTPUT 1.
- frame_start while busy: ignored, with no effect on the current frame.
- Reset mid-frame: immediate return to IDLE with outputs zeroed. Any finder end that arrives later is ignored.

Optional Feature:
- Macro SCHED_TIMEOUT_EN.
- Defined: a wait counter clears in LAUNCH and increments in WAIT.
  - When it reaches MAX_WAIT, any finder not yet done is treated as done with found = 0, and the FSM goes to SELECT.
  - Adds output timeout_err (1 bit): sticky, set on a timeout, cleared on the next accepted frame_start.
- Undefined: WAIT has no limit, and the timeout_err port is absent.

Test Plan:
- Reset, then frame_start with heading 0.0, NUM_COLS=4, col_ready=1 -> alpha_X sequence 30, 29 (frac 0x340), 29 (frac 0x280), 29 (frac 0x1C0); frame_done after the 4th transfer.
- Heading 10.0 -> first ray is 40.0. Heading 350.0 -> first ray is 20.0 (wrap down through 360). Heading 0.0 with FOV_HALF=0, ANGLE_STEP=1024 -> second ray is 359.0 (wrap below 0).
- Player (100,100); h hit (164,100); v hit (100,228), v_end 5 cycles before h_end -> hit_vert=0, dist_sq=4096, hit (164,100).
- Both finders report not found -> hit_found=0, dist_sq=0x7FFFFFF. Equal distances (4096 each) -> hit_vert=0.
- col_ready held low for 10 cycles in OUTPUT -> col_valid stays 1 with the record stable; a second frame_start during this time is ignored; a single transfer occurs when ready rises.
- SCHED_TIMEOUT_EN, MAX_WAIT=16, v_end never asserted -> SELECT on wait cycle 16 with the horizontal result; timeout_err=1. Asserting reset mid-WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/raycast_column_scheduler.sv
// Column sequencer for one ray-cast frame: steps the ray angle, launches both wall finders and emits the nearer hit.
// Optional wait limit with a sticky timeout_err output is enabled by defining SCHED_TIMEOUT_EN.
module raycast_column_scheduler #(
    parameter int NUM_COLS   = 320,
    parameter int FOV_HALF   = 30720,
    parameter int ANGLE_STEP = 192,
    parameter int MAX_WAIT   = 1024
) (
    input  logic                                            clock,
    input  logic                                            reset,
    input  logic                                            frame_start,
    input  logic signed [12:0]                              playerX,
    input  logic signed [12:0]                              playerY,
    input  logic signed [9:0]                               player_alpha_X,
    input  logic        [9:0]                               player_alpha_Y,
    output logic signed [9:0]                               alpha_X,
    output logic        [9:0]                               alpha_Y,
    output logic signed [12:0]                              ray_playerX,
    output logic signed [12:0]                              ray_playerY,
    output logic                                            begin_calc,
    input  logic                                            h_end,
    input  logic                                            v_end,
    input  logic                                            h_found,
    input  logic                                            v_found,
    input  logic signed [12:0]                              h_wallX,
    input  logic signed [12:0]                              h_wallY,
    input  logic signed [12:0]                              v_wallX,
    input  logic signed [12:0]                              v_wallY,
    output logic                                            col_valid,
    input  logic                                            col_ready,
    output logic [((NUM_COLS > 1) ? $clog2(NUM_COLS) : 1)-1:0] col_index,
    output logic signed [12:0]                              hit_x,
    output logic signed [12:0]                              hit_y,
    output logic                                            hit_vert,
    output logic                                            hit_found,
    output logic        [26:0]                              dist_sq,
    output logic                                            busy,
    output logic                                            frame_done
`ifdef SCHED_TIMEOUT_EN
    ,
    output logic                                            timeout_err
`endif
);

    localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);
    localparam logic signed [21:0] FULL_TURN = 22'sd368640;
    localparam logic signed [21:0] FOV_S     = 22'(FOV_HALF);
    localparam logic signed [21:0] STEP_S    = 22'(ANGLE_STEP);
    localparam logic [29:0] MAX_D = 30'h7FFFFFF;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_SELECT = 3'd3;
    localparam logic [2:0] S_OUTPUT = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    if (MAX_WAIT < 1) begin : g_bad_max_wait
        $error("MAX_WAIT must be at least 1");
    end

    // Angle is kept in [0, 360) degrees after every update.
    function automatic logic [19:0] wrap_angle(input logic signed [21:0] a);
        logic signed [21:0] r;
        r = a;
        if (a >= FULL_TURN)
            r = a - FULL_TURN;
        else if (a < 22'sd0)
            r = a + FULL_TURN;
        return r[19:0];
    endfunction

    // Squared distance saturates to all ones; that value also marks "no wall".
    function automatic logic [26:0] sq_dist(input logic signed [12:0] x, input logic signed [12:0] y,
                                            input logic signed [12:0] px, input logic signed [12:0] py);
        logic signed [28:0] dx;
        logic signed [28:0] dy;
        logic        [29:0] s;
        dx = 29'(x) - 29'(px);
        dy = 29'(y) - 29'(py);
        s  = 30'(dx * dx) + 30'(dy * dy);
        if (s > MAX_D)
            return '1;
        return s[26:0];
    endfunction

    logic [2:0]         state;
    logic [19:0]        angle;
    logic signed [19:0] heading;
    logic signed [21:0] start_sum;
    logic signed [21:0] step_sum;
    logic               h_done, v_done, h_fnd, v_fnd;
    logic signed [12:0] h_x, h_y, v_x, v_y;
    logic [26:0]        h_d, v_d;
    logic               pick_v;
`ifdef SCHED_TIMEOUT_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    logic [WAIT_W-1:0]  wait_cnt;
`endif

    assign alpha_X   = angle[19:10];
    assign alpha_Y   = angle[9:0];
    assign heading   = {player_alpha_X, player_alpha_Y};
    assign start_sum = heading + FOV_S;
    assign step_sum  = $signed({2'b00, angle}) - STEP_S;

    always_comb begin
        h_d    = sq_dist(h_x, h_y, ray_playerX, ray_playerY);
        v_d    = sq_dist(v_x, v_y, ray_playerX, ray_playerY);
        pick_v = v_fnd && (!h_fnd || (v_d < h_d));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            angle       <= '0;
            ray_playerX <= '0;
            ray_playerY <= '0;
            begin_calc  <= 1'b0;
            col_valid   <= 1'b0;
            col_index   <= '0;
            hit_x       <= '0;
            hit_y       <= '0;
            hit_vert    <= 1'b0;
            hit_found   <= 1'b0;
            dist_sq     <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            h_done      <= 1'b0;
            v_done      <= 1'b0;
            h_fnd       <= 1'b0;
            v_fnd       <= 1'b0;
            h_x         <= '0;
            h_y         <= '0;
            v_x         <= '0;
            v_y         <= '0;
`ifdef SCHED_TIMEOUT_EN
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        ray_playerX <= playerX;
                        ray_playerY <= playerY;
                        angle       <= wrap_angle(start_sum);
                        col_index   <= '0;
                        busy        <= 1'b1;
                        begin_calc  <= 1'b1;
                        state       <= S_LAUNCH;
`ifdef SCHED_TIMEOUT_EN
                        timeout_err <= 1'b0;
`endif
                    end
                end
                S_LAUNCH: begin
                    begin_calc <= 1'b0;
                    h_done     <= 1'b0;
                    v_done     <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
                    wait_cnt   <= '0;
`endif
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    // First end from each finder wins; repeats are ignored.
                    if (h_end && !h_done) begin
                        h_done <= 1'b1;
                        h_fnd  <= h_found;
                        h_x    <= h_wallX;
                        h_y    <= h_wallY;
                    end
                    if (v_end && !v_done) begin
                        v_done <= 1'b1;
                        v_fnd  <= v_found;
                        v_x    <= v_wallX;
                        v_y    <= v_wallY;
                    end
                    if (h_done && v_done) begin
                        state <= S_SELECT;
                    end
`ifdef SCHED_TIMEOUT_EN
                    else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
                        if (!h_done && !h_end) h_fnd <= 1'b0;
                        if (!v_done && !v_end) v_fnd <= 1'b0;
                        h_done      <= 1'b1;
                        v_done      <= 1'b1;
                        timeout_err <= 1'b1;
                        state       <= S_SELECT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                S_SELECT: begin
                    hit_found <= h_fnd | v_fnd;
                    hit_vert  <= pick_v;
                    if (!h_fnd && !v_fnd) begin
                        hit_x   <= '0;
                        hit_y   <= '0;
                        dist_sq <= '1;
                    end else if (pick_v) begin
                        hit_x   <= v_x;
                        hit_y   <= v_y;
                        dist_sq <= v_d;
                    end else begin
                        hit_x   <= h_x;
                        hit_y   <= h_y;
                        dist_sq <= h_d;
                    end
                    col_valid <= 1'b1;
                    state     <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    if (col_ready) begin
                        col_valid <= 1'b0;
                        if (col_index == LAST_COL) begin
                            frame_done <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            col_index  <= col_index + 1'b1;
                            angle      <= wrap_angle(step_sum);
                            begin_calc <= 1'b1;
                            state      <= S_LAUNCH;
                        end
                    end
                end
                S_DONE: begin
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
